serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one bit pair per cycle to an external full adder, LSB first.
// Latency: accept at edge N, out_valid high from edge N+WIDTH; one op per WIDTH+2 cycles minimum.
// Backpressure: result/cout held in DONE until out_ready; in_ready low whenever not IDLE.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand handshake (op_a, op_b, cin)
//   fa_a, fa_b, fa_c           bits driven to the external full adder (zero outside SHIFT)
//   fa_sum, fa_carry           full-adder combinational results
//   out_valid/out_ready        result handshake (result, cout)
//   busy                       high in SHIFT or DONE
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  // Counter holds 0..WIDTH, so it can never wrap inside one operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB and walk down, so after WIDTH shifts
        // the first (LSB) sum bit has reached bit 0.
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode registered state only; no input reaches an output combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign fa_a      = (state_q == SHIFT) ? a_q[0]  : 1'b0;
  assign fa_b      = (state_q == SHIFT) ? b_q[0]  : 1'b0;
  assign fa_c      = (state_q == SHIFT) ? carry_q : 1'b0;
  assign result    = res_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         fa_a, fa_b, fa_c;
  logic         fa_sum, fa_carry;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bound full adder
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("sum", {cout, result}, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W:0] exp, input bit hold, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1; op_a = a; op_b = b; cin = c;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      chk("accept_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) chk("out_valid_timeout", 1, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_fa"}, {fa_a, fa_b, fa_c}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    int acc1, acc2, k, nv;
    logic [W-1:0] ra, rb;
    logic rc;

    #2;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 0x05 + 0x03 + 0 : latency check
    send(8'h05, 8'h03, 1'b0, 9'h008, 0, acc1);
    chk("shift_busy", busy, 1);
    wait_out(k);
    chk("latency", k, W);
    @(negedge clk);

    // 0xFF + 0xFF + 1 : carry stays 1 on every bit
    send(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0, acc1);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("fa_c_bit%0d", i), fa_c, 1);
      @(negedge clk);
    end
    wait_out(k);
    @(negedge clk);

    // 0x80 + 0x80 held in DONE with out_ready low
    out_ready = 1'b0;
    send(8'h80, 8'h80, 1'b0, 9'h100, 0, acc1);
    wait_out(k);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op_a = 8'h11; op_b = 8'h22;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, 8'h00);
      chk("hold_cout", cout, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_fa_zero", {fa_a, fa_b, fa_c}, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_handshake", in_ready, 1);

    // Back-to-back with in_valid held high
    send(8'h0F, 8'h01, 1'b1, 9'h011, 1, acc1);
    send(8'hA5, 8'h5A, 1'b0, 9'h0FF, 0, acc2);
    chk("b2b_spacing", acc2 - acc1, W + 2);
    wait_out(k);
    @(negedge clk);

    // Reset during the 4th SHIFT cycle
    send(8'h55, 8'h0F, 1'b0, 9'h064, 0, acc1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    chk("accept_ready_after_reset", in_ready, 1);
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) nv++;
      @(negedge clk);
    end
    chk("no_out_after_abort", nv, 0);
    send(8'h12, 8'h34, 1'b0, 9'h046, 0, acc1);
    wait_out(k);
    @(negedge clk);

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}, 0, acc1);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
